router_cc: RTL and testbench

Five-port wormhole router for the Phoenix 2-D mesh NoC: one instance per mesh node, with ports East(0), West(1), North(2), South(3) and Local(4). It buffers incoming flits per input port and routes each packet with deterministic XY routing. A round-robin switch allocator arbitrates between inputs. Flow control on every link is credit-based.

---
 rtl/router_cc_if.sv | 22 ++
 rtl/router_cc.sv | 154 +++++++++++++++
 tb/tb_router_cc.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_cc_if.sv
// rtl/router_cc_if.sv - five-link flit bundle of the mesh router
// Bit p / slice [p*16 +: 16] belongs to port p: East, West, North, South, Local.
interface router_cc_if;
  logic [4:0]  i_credit;
  logic [4:0]  i_clk_rx;
  logic [4:0]  i_rx;
  logic [79:0] i_data;
  logic [4:0]  o_credit;
  logic [4:0]  o_clk_tx;
  logic [4:0]  o_tx;
  logic [79:0] o_data;

  modport slave (
    input  i_credit, i_clk_rx, i_rx, i_data,
    output o_credit, o_clk_tx, o_tx, o_data
  );

  modport master (
    output i_credit, i_clk_rx, i_rx, i_data,
    input  o_credit, o_clk_tx, o_tx, o_data
  );
endinterface

// File: rtl/router_cc.sv
// rtl/router_cc.sv - five-port XY wormhole router with credit flow control
// ROUTERCC_SHALLOW_BUF_EN selects 4-deep input buffers instead of 16-deep.
module router_cc #(
  parameter logic [15:0] address = 16'h0000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  router_cc_if.slave bus
);

`ifdef ROUTERCC_SHALLOW_BUF_EN
  localparam int PW = 2;
`else
  localparam int PW = 4;
`endif
  localparam int DEPTH = 1 << PW;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [15:0]   r_mem [5][DEPTH];
  logic [PW-1:0] r_wr_ptr [5];
  logic [PW-1:0] r_rd_ptr [5];
  logic [PW:0]   r_cnt [5];

  logic [4:0]  r_conn;
  logic [2:0]  r_sel [5];
  logic [4:0]  r_hdr_done;
  logic [4:0]  r_size_done;
  logic [15:0] r_remain [5];
  logic [4:0]  r_busy;
  logic [2:0]  r_owner [5];
  logic [2:0]  r_rr_ptr;

  logic [15:0] w_head [5];
  logic [2:0]  w_route [5];
  logic [4:0]  w_full, w_empty, w_push, w_pop, w_last, w_elig;
  logic        w_gnt_vld;
  logic [2:0]  w_gnt_idx;
  logic [4:0]  w_tx;
  logic [79:0] w_odata;
  logic        w_unused_clk_rx;

  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= 5) s = s - 5;
    return 3'(s);
  endfunction

  function automatic logic [2:0] xy_route(input logic [15:0] hdr);
    if (hdr[15:8] > address[15:8])      return 3'd0;
    else if (hdr[15:8] < address[15:8]) return 3'd1;
    else if (hdr[7:0] > address[7:0])   return 3'd2;
    else if (hdr[7:0] < address[7:0])   return 3'd3;
    else                                return 3'd4;
  endfunction

  assign w_unused_clk_rx = ^bus.i_clk_rx;

  always_comb begin
    for (int p = 0; p < 5; p++) begin
      w_head[p]  = r_mem[p][r_rd_ptr[p]];
      w_route[p] = xy_route(w_head[p]);
      w_empty[p] = (r_cnt[p] == '0);
      w_full[p]  = (r_cnt[p] == FULL_CNT);
      w_push[p]  = bus.i_rx[p] && !w_full[p];
      w_pop[p]   = r_conn[p] && !w_empty[p] && bus.i_credit[r_sel[p]];
      // Flit 1 carrying size 0 ends the packet; otherwise the last payload does.
      w_last[p]  = r_size_done[p] ? (r_remain[p] == 16'd1)
                                  : (r_hdr_done[p] && (w_head[p] == 16'd0));
      w_elig[p]  = !r_conn[p] && !w_empty[p] && !r_busy[w_route[p]];
    end
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = 3'd0;
    for (int k = 0; k < 5; k++) begin
      if (!w_gnt_vld && w_elig[rr_idx(r_rr_ptr, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = rr_idx(r_rr_ptr, k);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int p = 0; p < 5; p++) begin
      if (w_push[p]) r_mem[p][r_wr_ptr[p]] <= bus.i_data[p*16 +: 16];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int p = 0; p < 5; p++) begin
        r_wr_ptr[p] <= '0;
        r_rd_ptr[p] <= '0;
        r_cnt[p]    <= '0;
        r_sel[p]    <= 3'd0;
        r_remain[p] <= 16'd0;
        r_owner[p]  <= 3'd0;
      end
      r_conn      <= 5'd0;
      r_hdr_done  <= 5'd0;
      r_size_done <= 5'd0;
      r_busy      <= 5'd0;
      r_rr_ptr    <= 3'd0;
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (w_push[p]) r_wr_ptr[p] <= r_wr_ptr[p] + PW'(1);
        if (w_pop[p])  r_rd_ptr[p] <= r_rd_ptr[p] + PW'(1);
        r_cnt[p] <= r_cnt[p] + {{PW{1'b0}}, w_push[p]} - {{PW{1'b0}}, w_pop[p]};
        if (w_pop[p]) begin
          if (w_last[p]) begin
            r_conn[p]         <= 1'b0;
            r_hdr_done[p]     <= 1'b0;
            r_size_done[p]    <= 1'b0;
            r_busy[r_sel[p]]  <= 1'b0;
          end else if (!r_hdr_done[p]) begin
            r_hdr_done[p] <= 1'b1;
          end else if (!r_size_done[p]) begin
            r_size_done[p] <= 1'b1;
            r_remain[p]    <= w_head[p];
          end else begin
            r_remain[p] <= r_remain[p] - 16'd1;
          end
        end
      end
      // Granted output was free, so it cannot also be released at this edge.
      if (w_gnt_vld) begin
        r_conn[w_gnt_idx]           <= 1'b1;
        r_sel[w_gnt_idx]            <= w_route[w_gnt_idx];
        r_busy[w_route[w_gnt_idx]]  <= 1'b1;
        r_owner[w_route[w_gnt_idx]] <= w_gnt_idx;
        r_rr_ptr                    <= rr_idx(w_gnt_idx, 1);
      end
    end
  end

  always_comb begin
    w_tx    = 5'd0;
    w_odata = 80'd0;
    for (int o = 0; o < 5; o++) begin
      if (r_busy[o]) begin
        w_tx[o]             = !w_empty[r_owner[o]];
        w_odata[o*16 +: 16] = w_head[r_owner[o]];
      end
    end
  end

  assign bus.o_tx     = w_tx;
  assign bus.o_data   = w_odata;
  assign bus.o_credit = ~w_full;
  assign bus.o_clk_tx = {5{i_clk}};

endmodule

// File: tb/tb_router_cc.sv
// tb/tb_router_cc.sv - self-checking bench for router_cc at node 16'h0101
// Directed tables, multi-cycle corner sequences and a randomized scoreboard run.
module tb_router_cc;

`ifdef ROUTERCC_SHALLOW_BUF_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 16;
`endif
  localparam int MY_X = 1;
  localparam int MY_Y = 1;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  router_cc_if bus();
  router_cc #(.address(16'h0101)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rx;
    logic [15:0] din;
    logic        tx_exp;
    logic [15:0] dout_exp;
  } lane_vec_t;

  typedef struct {
    logic [15:0] hdr;
    int          port;
  } xy_vec_t;

  lane_vec_t   loc_tab[6];
  xy_vec_t     xy_tab[8];
  logic [15:0] cont_dat[9];
  logic        cont_tx[9];
  logic [15:0] pkt[32];
  logic [15:0] got_q[$];
  logic [15:0] srcq[5][$];
  logic [15:0] expq[5][5][$];
  logic [15:0] rbuf[5][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [15:0] odat(input int p);
    return bus.o_data[p*16 +: 16];
  endfunction

  function automatic int xy_ref(input logic [15:0] hdr);
    int dx, dy;
    dx = int'(hdr[15:8]);
    dy = int'(hdr[7:0]);
    if (dx != MY_X) return (dx > MY_X) ? 0 : 1;
    if (dy != MY_Y) return (dy > MY_Y) ? 2 : 3;
    return 4;
  endfunction

  task automatic do_reset();
    bus.i_rx = 5'd0;
    bus.i_credit = 5'h1F;
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    int wi, cyc, got, port, L, matched, ok, left;
    logic [4:0] sent;
    logic [15:0] hdr;

    loc_tab = '{'{1'b1, 16'h0101, 1'b0, 16'h0000}, '{1'b1, 16'h0002, 1'b1, 16'h0101},
                '{1'b1, 16'hAAAA, 1'b1, 16'h0002}, '{1'b1, 16'hBBBB, 1'b1, 16'hAAAA},
                '{1'b0, 16'h0000, 1'b1, 16'hBBBB}, '{1'b0, 16'h0000, 1'b0, 16'h0000}};
    xy_tab = '{'{16'h0201, 0}, '{16'h0001, 1}, '{16'h0102, 2}, '{16'h0100, 3},
               '{16'h0101, 4}, '{16'h0205, 0}, '{16'h0000, 1}, '{16'h01FF, 2}};
    cont_tx  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    cont_dat = '{16'h0, 16'h0101, 16'h0001, 16'h1111, 16'h0,
                 16'h0101, 16'h0001, 16'h3333, 16'h0};

    bus.i_rx = 5'd0;
    bus.i_data = 80'd0;
    bus.i_credit = 5'h1F;
    bus.i_clk_rx = 5'd0;
    #2;
    chk("rst_tx", 32'(bus.o_tx), 32'h0);
    chk("rst_data", 32'(bus.o_data != 80'd0), 32'h0);
    chk("rst_credit", 32'(bus.o_credit), 32'h1F);
    chk("clk_tx", 32'(bus.o_clk_tx), 32'({5{i_clk}}));
    tick();
    i_rst = 1'b0;

    // Local delivery: two-cycle header latency, in-order stream, release
    for (int s = 0; s < 6; s++) begin
      bus.i_rx[4] = loc_tab[s].rx;
      bus.i_data[64 +: 16] = loc_tab[s].din;
      tick();
      chk($sformatf("local_tx[%0d]", s), 32'(bus.o_tx), 32'({loc_tab[s].tx_exp, 4'b0000}));
      chk($sformatf("local_data[%0d]", s), 32'(odat(4)), 32'(loc_tab[s].dout_exp));
    end

    // XY direction from Local with zero-length packets
    for (int v = 0; v < 8; v++) begin
      bus.i_rx[4] = 1'b1;
      bus.i_data[64 +: 16] = xy_tab[v].hdr;
      tick();
      bus.i_data[64 +: 16] = 16'h0000;
      tick();
      bus.i_rx[4] = 1'b0;
      got = 0;
      for (int c = 0; c < 8 && got == 0; c++) begin
        if (bus.o_tx != 5'd0) got = 1;
        else tick();
      end
      chk($sformatf("xy_seen[%0d]", v), 32'(got), 32'd1);
      port = -1;
      for (int o = 0; o < 5; o++) if (bus.o_tx[o]) port = o;
      chk($sformatf("xy_port[%0d]", v), 32'(port), 32'(xy_tab[v].port));
      chk($sformatf("xy_onehot[%0d]", v), 32'($countones(bus.o_tx)), 32'd1);
      if (port >= 0) chk($sformatf("xy_hdr[%0d]", v), 32'(odat(port)), 32'(xy_tab[v].hdr));
      for (int c = 0; c < 8 && bus.o_tx != 5'd0; c++) tick();
      chk($sformatf("xy_release[%0d]", v), 32'(bus.o_tx), 32'h0);
    end

    // Contention: West and South to Local in the same cycle
    do_reset();
    for (int s = 0; s < 9; s++) begin
      bus.i_rx[1] = (s < 3);
      bus.i_rx[3] = (s < 3);
      bus.i_data[16 +: 16] = (s == 0) ? 16'h0101 : (s == 1) ? 16'h0001 : 16'h1111;
      bus.i_data[48 +: 16] = (s == 0) ? 16'h0101 : (s == 1) ? 16'h0001 : 16'h3333;
      tick();
      chk($sformatf("cont_tx[%0d]", s), 32'(bus.o_tx), 32'({cont_tx[s], 4'b0000}));
      chk($sformatf("cont_data[%0d]", s), 32'(odat(4)), 32'(cont_dat[s]));
    end
    bus.i_rx = 5'd0;

    // Backpressure: East blocked, fill the Local buffer, then drain
    do_reset();
    pkt[0] = 16'h0201;
    pkt[1] = 16'd30;
    for (int i = 2; i < 32; i++) pkt[i] = 16'hC000 + 16'(i);
    bus.i_credit = 5'h1E;
    wi = 0;
    cyc = 0;
    while (bus.o_credit[4] && cyc < 40) begin
      bus.i_rx[4] = 1'b1;
      bus.i_data[64 +: 16] = pkt[wi];
      tick();
      wi++;
      cyc++;
    end
    chk("full_count", 32'(wi), 32'(DEPTH));
    chk("full_credit", 32'(bus.o_credit), 32'h0F);
    chk("blocked_tx", 32'(bus.o_tx), 32'h01);
    chk("blocked_head", 32'(odat(0)), 32'h0201);
    bus.i_data[64 +: 16] = 16'hDEAD;
    tick();
    chk("drop_credit", 32'(bus.o_credit[4]), 32'h0);
    bus.i_rx[4] = 1'b0;
    bus.i_credit = 5'h1F;
    got_q.delete();
    cyc = 0;
    while (got_q.size() < 32 && cyc < 200) begin
      bus.i_rx[4] = (wi < 32) && bus.o_credit[4];
      if (wi < 32) bus.i_data[64 +: 16] = pkt[wi];
      sent[4] = bus.i_rx[4];
      if (bus.o_tx[0]) got_q.push_back(odat(0));
      tick();
      if (sent[4]) wi++;
      cyc++;
    end
    bus.i_rx = 5'd0;
    chk("drain_len", 32'(got_q.size()), 32'd32);
    for (int i = 0; i < 32 && i < got_q.size(); i++)
      chk($sformatf("drain_flit[%0d]", i), 32'(got_q[i]), 32'(pkt[i]));
    tick();
    chk("drain_release", 32'(bus.o_tx), 32'h0);

    // Reset asserted mid-packet
    do_reset();
    pkt[0] = 16'h0201; pkt[1] = 16'd5; pkt[2] = 16'h5A00; pkt[3] = 16'h5A01;
    for (int i = 0; i < 4; i++) begin
      bus.i_rx[4] = 1'b1;
      bus.i_data[64 +: 16] = pkt[i];
      tick();
    end
    bus.i_rx[4] = 1'b0;
    chk("mid_tx", 32'(bus.o_tx), 32'h01);
    #2;
    i_rst = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(bus.o_tx), 32'h0);
    chk("mid_rst_credit", 32'(bus.o_credit), 32'h1F);
    chk("mid_rst_data", 32'(bus.o_data != 80'd0), 32'h0);
    tick();
    tick();
    i_rst = 1'b0;
    bus.i_rx[4] = 1'b1;
    bus.i_data[64 +: 16] = 16'h0101;
    tick();
    bus.i_data[64 +: 16] = 16'h0000;
    tick();
    bus.i_rx[4] = 1'b0;
    chk("post_rst_tx", 32'(bus.o_tx), 32'h10);
    chk("post_rst_hdr", 32'(odat(4)), 32'h0101);
    tick();
    tick();
    chk("post_rst_release", 32'(bus.o_tx), 32'h0);

    // Randomized traffic against a packet scoreboard
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 6; k++) begin
        hdr = {8'($urandom_range(0, 2)), 8'($urandom_range(0, 2))};
        L = $urandom_range(0, 4);
        srcq[p].push_back(hdr);
        srcq[p].push_back(16'(L));
        expq[p][xy_ref(hdr)].push_back(hdr);
        expq[p][xy_ref(hdr)].push_back(16'(L));
        for (int j = 0; j < L; j++) begin
          srcq[p].push_back({4'(p), 4'(k), 8'(j)});
          expq[p][xy_ref(hdr)].push_back({4'(p), 4'(k), 8'(j)});
        end
      end
    end
    cyc = 0;
    left = 1;
    while (left != 0 && cyc < 3000) begin
      for (int p = 0; p < 5; p++) begin
        sent[p] = (srcq[p].size() > 0) && bus.o_credit[p] && ($urandom_range(0, 3) != 0);
        bus.i_rx[p] = sent[p];
        if (sent[p]) bus.i_data[p*16 +: 16] = srcq[p][0];
      end
      for (int o = 0; o < 5; o++) bus.i_credit[o] = ($urandom_range(0, 3) != 0);
      for (int o = 0; o < 5; o++)
        if (bus.o_tx[o] && bus.i_credit[o]) rbuf[o].push_back(odat(o));
      tick();
      for (int p = 0; p < 5; p++) if (sent[p]) void'(srcq[p].pop_front());
      for (int o = 0; o < 5; o++) begin
        if (rbuf[o].size() >= 2 && rbuf[o].size() == int'(rbuf[o][1]) + 2) begin
          L = rbuf[o].size();
          matched = 0;
          for (int i = 0; i < 5 && matched == 0; i++) begin
            if (expq[i][o].size() >= L) begin
              ok = 1;
              for (int j = 0; j < L; j++) if (expq[i][o][j] !== rbuf[o][j]) ok = 0;
              if (ok != 0) begin
                matched = 1;
                repeat (L) void'(expq[i][o].pop_front());
              end
            end
          end
          chk($sformatf("rand_pkt_out%0d_hdr%h", o, rbuf[o][0]), 32'(matched), 32'd1);
          rbuf[o].delete();
        end
      end
      left = 0;
      for (int p = 0; p < 5; p++) begin
        left += srcq[p].size();
        for (int o = 0; o < 5; o++) left += expq[p][o].size();
      end
      cyc++;
    end
    bus.i_rx = 5'd0;
    chk("rand_drained", 32'(left), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
